// File: rtl/mem_stage_vector_lsu_if.sv
// mem_stage_vector_lsu_if: EX/MEM inputs, data-memory port and MEM/WB bundle of the vector LSU
interface mem_stage_vector_lsu_if #(
   parameter int N  = 32,
   parameter int V  = 20,
   parameter int AW = 10
);
   logic                  RegFile_WE_i, MemWE_i, WBSelect_i, OpSource_i;
   logic [3:0]            A3_i;
   logic [N-1:0]          AluResult_S_i, RD2_S_i;
   logic [V-1:0][N-1:0]   RD2_V_i, AluResult_V_i;
   logic                  stall_o;
   logic [AW-1:0]         mem_addr_o;
   logic [N-1:0]          mem_wdata_o;
   logic                  mem_we_o;
   logic [N-1:0]          mem_rdata_i;
   logic                  valid_o, RegFile_WE_o, WBSelect_o, OpSource_o;
   logic [3:0]            A3_o;
   logic [N-1:0]          AluResult_S_o, ReadData_S_o;
   logic [V-1:0][N-1:0]   AluResult_V_o, ReadData_V_o;
   modport slave (
      input  RegFile_WE_i, MemWE_i, WBSelect_i, OpSource_i, A3_i, AluResult_S_i, RD2_S_i,
             RD2_V_i, AluResult_V_i, mem_rdata_i,
      output stall_o, mem_addr_o, mem_wdata_o, mem_we_o, valid_o, RegFile_WE_o, WBSelect_o,
             OpSource_o, A3_o, AluResult_S_o, ReadData_S_o, AluResult_V_o, ReadData_V_o
   );
   modport master (
      output RegFile_WE_i, MemWE_i, WBSelect_i, OpSource_i, A3_i, AluResult_S_i, RD2_S_i,
             RD2_V_i, AluResult_V_i, mem_rdata_i,
      input  stall_o, mem_addr_o, mem_wdata_o, mem_we_o, valid_o, RegFile_WE_o, WBSelect_o,
             OpSource_o, A3_o, AluResult_S_o, ReadData_S_o, AluResult_V_o, ReadData_V_o
   );
endinterface

// File: rtl/mem_stage_vector_lsu.sv
// mem_stage_vector_lsu: serializes scalar/vector loads and stores onto a one-word memory port
module mem_stage_vector_lsu #(
   parameter int N  = 32,
   parameter int V  = 20,
   parameter int AW = 10
) (
   input logic                    CLK,
   input logic                    RST,
   mem_stage_vector_lsu_if.slave  bus
);
   localparam int LW = $clog2(V);
   localparam int KW = LW + 1;
   typedef enum logic [1:0] {IDLE, VST, RD, DRAIN} state_t;
   state_t state, nstate;
   logic [KW-1:0] k, nk;
   logic [LW-1:0] ki, prev;
   logic done, is_mem;
   assign ki     = k[LW-1:0];
   assign prev   = ki - 1'b1;
   assign is_mem = bus.MemWE_i | bus.WBSelect_i;
   // next state, lane counter, memory port and stall; IDLE issues lane 0 of every memory op
   always_comb begin
      nstate          = state;
      nk              = k;
      done            = 1'b0;
      bus.stall_o     = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = bus.AluResult_S_i[AW-1:0] + AW'(k);
      bus.mem_wdata_o = bus.OpSource_i ? bus.RD2_V_i[ki] : bus.RD2_S_i;
      case (state)
         IDLE: begin
            bus.mem_we_o = bus.MemWE_i;
            bus.stall_o  = is_mem & (bus.OpSource_i | ~bus.MemWE_i);
            done         = ~bus.stall_o;
            nk           = bus.stall_o & bus.OpSource_i ? KW'(1) : '0;
            nstate       = ~bus.stall_o ? IDLE : ~bus.OpSource_i ? DRAIN : bus.MemWE_i ? VST : RD;
         end
         VST: begin
            bus.mem_we_o = 1'b1;
            done         = k == KW'(V - 1);
            bus.stall_o  = ~done;
            nk           = done ? '0 : k + 1'b1;
            nstate       = done ? IDLE : VST;
         end
         RD: begin
            bus.stall_o = 1'b1;
            nk          = k + 1'b1;
            nstate      = k == KW'(V - 1) ? DRAIN : RD;
         end
         default: begin
            done   = 1'b1;
            nk     = '0;
            nstate = IDLE;
         end
      endcase
      if (!RST) begin
         bus.stall_o  = 1'b0;
         bus.mem_we_o = 1'b0;
      end
   end
   // state, counter and MEM/WB register; bubbles while busy, full bundle on the completion edge
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state             <= IDLE;
         k                 <= '0;
         bus.valid_o       <= 1'b0;
         bus.RegFile_WE_o  <= 1'b0;
         bus.WBSelect_o    <= 1'b0;
         bus.OpSource_o    <= 1'b0;
         bus.A3_o          <= '0;
         bus.AluResult_S_o <= '0;
         bus.ReadData_S_o  <= '0;
         bus.AluResult_V_o <= '0;
         bus.ReadData_V_o  <= '0;
      end else begin
         state             <= nstate;
         k                 <= nk;
         bus.valid_o       <= done & (is_mem | bus.RegFile_WE_i);
         bus.RegFile_WE_o  <= done & bus.RegFile_WE_i & ~bus.MemWE_i;
         bus.WBSelect_o    <= bus.WBSelect_i;
         bus.OpSource_o    <= bus.OpSource_i;
         bus.A3_o          <= bus.A3_i;
         bus.AluResult_S_o <= bus.AluResult_S_i;
         bus.AluResult_V_o <= bus.AluResult_V_i;
         if (state == RD || (state == DRAIN && bus.OpSource_i)) bus.ReadData_V_o[prev] <= bus.mem_rdata_i;
         if (state == DRAIN && !bus.OpSource_i) bus.ReadData_S_o <= bus.mem_rdata_i;
      end
   end
endmodule
